// File: rtl/spi_cmd_scheduler_pkg.sv
// Shared types and command-field layout for the SPI command scheduler.
// Command word: {ss_addr[1:0], data, addr, size[1:0], write}.
package spi_cmd_scheduler_pkg;

   localparam int DWIDTH = 8;
   localparam int AWIDTH = 8;
   localparam int CMD_W  = DWIDTH + AWIDTH + 5;

   localparam int SS_MSB   = CMD_W - 1;
   localparam int SS_LSB   = CMD_W - 2;
   localparam int SIZE_MSB = 2;
   localparam int SIZE_LSB = 1;

   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   typedef enum logic [0:0] {
      SCH_IDLE   = 1'b0,
      SCH_ACTIVE = 1'b1
   } sched_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   function automatic logic cmd_is_illegal(input logic [CMD_W-1:0] cmd);
      return (cmd[SIZE_MSB:SIZE_LSB] == SIZE_ILLEGAL);
   endfunction

endpackage

// File: rtl/spi_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches i_req starting one past i_ptr
// and returns a one-hot grant plus the granted index.
module spi_rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_ptr,
   output logic [NREQ-1:0]         o_grant,
   output logic [$clog2(NREQ)-1:0] o_idx,
   output logic                    o_any
);

   localparam int IDXW = $clog2(NREQ);

   // First requester found after the pointer (wrapping) wins.
   always_comb begin
      int c;
      c       = 0;
      o_grant = {NREQ{1'b0}};
      o_idx   = {IDXW{1'b0}};
      o_any   = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         c = (int'(i_ptr) + i) % NREQ;
         if (!o_any && i_req[c]) begin
            o_grant[c] = 1'b1;
            o_idx      = IDXW'(c);
            o_any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Shares one spi_master among NREQ requesters: round-robin grant, per-slave
// SPI mode lookup, command hold register, done/err return and in-flight timeout.
module spi_cmd_scheduler
   import spi_cmd_scheduler_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            i_req_valid,
   input  logic [NREQ-1:0][CMD_W-1:0] i_req_cmd,
   output logic [NREQ-1:0]            o_req_ready,
   output logic [NREQ-1:0]            o_done,
   output logic [NREQ-1:0]            o_err,
   input  logic                       i_cfg_we,
   input  logic [1:0]                 i_cfg_ss,
   input  logic [1:0]                 i_cfg_mode,
   output logic                       o_master_en,
   output logic [CMD_W-1:0]           o_driver_data,
   output logic [1:0]                 o_driver_cfg,
   input  logic                       i_driver_read,
   output logic                       o_busy
);

   localparam int IDXW = $clog2(NREQ);
   localparam int TW   = $clog2(TIMEOUT + 1);

   sched_state_t     r_state, w_state_nxt;
   logic [CMD_W-1:0] r_data, w_data_nxt;
   spi_mode_t        r_cfg, w_cfg_nxt;
   spi_mode_t        r_mode [4];
   logic [IDXW-1:0]  r_owner, w_owner_nxt;
   logic [IDXW-1:0]  r_ptr, w_ptr_nxt;
   logic [TW-1:0]    r_timer, w_timer_nxt;
   logic [NREQ-1:0]  r_done, w_done_nxt;
   logic [NREQ-1:0]  r_err, w_err_nxt;

   logic [NREQ-1:0]  w_grant;
   logic [IDXW-1:0]  w_idx;
   logic             w_any;
   logic             w_accept;
   logic             w_hs;
   logic             w_illegal;
   logic [CMD_W-1:0] w_sel_cmd;
   logic [1:0]       w_sel_ss;
   spi_mode_t        w_sel_mode;

   spi_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_accept  = (r_state == SCH_IDLE) || ((r_state == SCH_ACTIVE) && i_driver_read);
   assign w_hs      = w_accept && w_any;
   assign w_sel_cmd = i_req_cmd[w_idx];
   assign w_sel_ss  = w_sel_cmd[SS_MSB:SS_LSB];
   assign w_illegal = cmd_is_illegal(w_sel_cmd);
   // A cfg write to the slave being captured this cycle must be seen by the capture.
   assign w_sel_mode = (i_cfg_we && (i_cfg_ss == w_sel_ss)) ? spi_mode_t'(i_cfg_mode)
                                                            : r_mode[w_sel_ss];

   assign o_req_ready   = w_accept ? w_grant : {NREQ{1'b0}};
   assign o_done        = r_done;
   assign o_err         = r_err;
   assign o_master_en   = (r_state == SCH_ACTIVE);
   assign o_busy        = (r_state == SCH_ACTIVE);
   assign o_driver_data = r_data;
   assign o_driver_cfg  = r_cfg;

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_cfg_nxt   = r_cfg;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_timer_nxt = r_timer;
      w_done_nxt  = {NREQ{1'b0}};
      w_err_nxt   = {NREQ{1'b0}};
      case (r_state)
         SCH_IDLE: begin
            if (w_hs) begin
               w_ptr_nxt = w_idx;
               if (w_illegal) begin
                  w_err_nxt[w_idx] = 1'b1;
               end else begin
                  w_data_nxt  = w_sel_cmd;
                  w_cfg_nxt   = w_sel_mode;
                  w_owner_nxt = w_idx;
                  w_timer_nxt = {TW{1'b0}};
                  w_state_nxt = SCH_ACTIVE;
               end
            end else begin
               w_state_nxt = SCH_IDLE;
            end
         end
         SCH_ACTIVE: begin
            // Completion beats timeout when both land in the same cycle.
            if (i_driver_read) begin
               w_done_nxt[r_owner] = 1'b1;
               if (w_hs) begin
                  w_ptr_nxt = w_idx;
                  if (w_illegal) begin
                     w_err_nxt[w_idx] = 1'b1;
                     w_state_nxt      = SCH_IDLE;
                  end else begin
                     w_data_nxt  = w_sel_cmd;
                     w_cfg_nxt   = w_sel_mode;
                     w_owner_nxt = w_idx;
                     w_timer_nxt = {TW{1'b0}};
                     w_state_nxt = SCH_ACTIVE;
                  end
               end else begin
                  w_state_nxt = SCH_IDLE;
               end
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
               w_err_nxt[r_owner] = 1'b1;
               w_state_nxt        = SCH_IDLE;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         default: begin
            w_state_nxt = SCH_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SCH_IDLE;
         r_data  <= {CMD_W{1'b0}};
         r_cfg   <= spi_mode_t'(2'b00);
         r_owner <= {IDXW{1'b0}};
         r_ptr   <= IDXW'(NREQ - 1);
         r_timer <= {TW{1'b0}};
         r_done  <= {NREQ{1'b0}};
         r_err   <= {NREQ{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_cfg   <= w_cfg_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_timer <= w_timer_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Per-slave mode table; consulted only at capture time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 4; s++) begin
            r_mode[s] <= spi_mode_t'(2'b00);
         end
      end else if (i_cfg_we) begin
         r_mode[i_cfg_ss] <= spi_mode_t'(i_cfg_mode);
      end
   end

endmodule
